// File: rtl/pixel_packet_receiver.sv
// Dibit-link packet deserializer: header address then pixel bytes, one
// frame-buffer write per pixel at base+index.
module pixel_packet_receiver #(
    parameter int unsigned PIXELS_PER_PACKET = 320,
    parameter int unsigned ADDR_BYTES        = 3,
    parameter int unsigned ADDR_W            = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              axiiv,
    input  logic [1:0]        axiid,
    output logic              pixel_valid,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic [7:0]        pixel_data,
    output logic              packet_done,
    output logic              packet_error,
    output logic              busy
);

    localparam int unsigned IDX_W  = $clog2(PIXELS_PER_PACKET + 1);
    localparam int unsigned HCNT_W = $clog2(ADDR_BYTES + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_PIXEL = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    logic [2:0]        state, state_d;
    logic [1:0]        dib_cnt, dib_cnt_d;
    logic [HCNT_W-1:0] hdr_cnt, hdr_cnt_d;
    logic [ADDR_W-1:0] hdr, hdr_d;
    logic [5:0]        byte_sr, byte_sr_d;
    logic [IDX_W-1:0]  index, index_d;
    logic              pixel_valid_d, packet_done_d, packet_error_d, busy_d;
    logic [ADDR_W-1:0] pixel_addr_d;
    logic [7:0]        pixel_data_d;
    logic [7:0]        full_byte;

    // Next-state and next-output logic; hdr doubles as the latched base address.
    always_comb begin
        state_d        = state;
        dib_cnt_d      = dib_cnt;
        hdr_cnt_d      = hdr_cnt;
        hdr_d          = hdr;
        byte_sr_d      = byte_sr;
        index_d        = index;
        pixel_valid_d  = 1'b0;
        pixel_addr_d   = pixel_addr;
        pixel_data_d   = pixel_data;
        packet_done_d  = 1'b0;
        packet_error_d = 1'b0;
        full_byte      = {axiid, byte_sr};

        case (state)
            S_IDLE: begin
                if (axiiv) begin
                    byte_sr_d = full_byte[7:2];
                    dib_cnt_d = 2'd1;
                    hdr_cnt_d = '0;
                    hdr_d     = '0;
                    state_d   = S_ADDR;
                end
            end
            S_ADDR: begin
                if (!axiiv) begin
                    packet_error_d = 1'b1;
                    state_d        = S_ERROR;
                end else begin
                    byte_sr_d = full_byte[7:2];
                    dib_cnt_d = dib_cnt + 2'd1;
                    if (dib_cnt == 2'd3) begin
                        hdr_d     = ADDR_W'({hdr, full_byte});
                        hdr_cnt_d = hdr_cnt + HCNT_W'(1);
                        if (hdr_cnt == HCNT_W'(ADDR_BYTES - 1)) begin
                            index_d = '0;
                            state_d = S_PIXEL;
                        end
                    end
                end
            end
            S_PIXEL: begin
                if (!axiiv) begin
                    packet_error_d = 1'b1;
                    state_d        = S_ERROR;
                end else begin
                    byte_sr_d = full_byte[7:2];
                    dib_cnt_d = dib_cnt + 2'd1;
                    if (dib_cnt == 2'd3) begin
                        pixel_valid_d = 1'b1;
                        pixel_data_d  = full_byte;
                        pixel_addr_d  = hdr + ADDR_W'(index);
                        index_d       = index + IDX_W'(1);
                        if (index == IDX_W'(PIXELS_PER_PACKET - 1)) begin
                            packet_done_d = 1'b1;
                            state_d       = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (!axiiv) state_d = S_IDLE;
            end
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_ADDR) || (state_d == S_PIXEL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            dib_cnt      <= '0;
            hdr_cnt      <= '0;
            hdr          <= '0;
            byte_sr      <= '0;
            index        <= '0;
            pixel_valid  <= 1'b0;
            pixel_addr   <= '0;
            pixel_data   <= '0;
            packet_done  <= 1'b0;
            packet_error <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_d;
            dib_cnt      <= dib_cnt_d;
            hdr_cnt      <= hdr_cnt_d;
            hdr          <= hdr_d;
            byte_sr      <= byte_sr_d;
            index        <= index_d;
            pixel_valid  <= pixel_valid_d;
            pixel_addr   <= pixel_addr_d;
            pixel_data   <= pixel_data_d;
            packet_done  <= packet_done_d;
            packet_error <= packet_error_d;
            busy         <= busy_d;
        end
    end

endmodule

// File: tb/tb_pixel_packet_receiver.sv
// Directed bench for pixel_packet_receiver: header/pixel packets, aborts,
// address wrap, drain and async reset.
module tb_pixel_packet_receiver;

    localparam int unsigned NPIX = 320;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        axiiv = 1'b0;
    logic [1:0]  axiid = 2'd0;
    logic        pixel_valid;
    logic [16:0] pixel_addr;
    logic [7:0]  pixel_data;
    logic        packet_done;
    logic        packet_error;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [16:0] wq_addr[$];
    logic [7:0]  wq_data[$];
    int done_cnt = 0, err_cnt = 0, done_alone = 0, both_cnt = 0;

    pixel_packet_receiver dut (
        .clk          (clk),
        .rst          (rst),
        .axiiv        (axiiv),
        .axiid        (axiid),
        .pixel_valid  (pixel_valid),
        .pixel_addr   (pixel_addr),
        .pixel_data   (pixel_data),
        .packet_done  (packet_done),
        .packet_error (packet_error),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (pixel_valid) begin
            wq_addr.push_back(pixel_addr);
            wq_data.push_back(pixel_data);
        end
        if (packet_done) done_cnt++;
        if (packet_done && !pixel_valid) done_alone++;
        if (packet_error) err_cnt++;
        if (packet_done && packet_error) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int i, input int mode);
        return (mode == 0) ? 8'(i) : 8'(i * 7 + 3);
    endfunction

    task automatic clear_mon();
        wq_addr.delete();
        wq_data.delete();
        done_cnt = 0; err_cnt = 0; done_alone = 0; both_cnt = 0;
    endtask

    task automatic drive_dibit(input logic [1:0] d);
        @(negedge clk);
        axiiv = 1'b1;
        axiid = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            axiiv = 1'b0;
            axiid = 2'd0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int k = 0; k < 4; k++) drive_dibit(b[2*k +: 2]);
    endtask

    task automatic send_hdr(input logic [23:0] h);
        send_byte(h[23:16]);
        send_byte(h[15:8]);
        send_byte(h[7:0]);
    endtask

    task automatic send_pixels(input int first, input int n, input int mode);
        for (int i = first; i < first + n; i++) send_byte(pat(i, mode));
    endtask

    task automatic expect_writes(input string tag, input int n, input int base,
                                 input int mode, input int first);
        check({tag, "_count"}, 32'(wq_addr.size()), 32'(n));
        for (int i = first; i < n && i < wq_addr.size(); i++) begin
            check({tag, "_addr"}, 32'(wq_addr[i]), 32'((base + i) & 32'h1FFFF));
            check({tag, "_data"}, 32'(wq_data[i]), 32'(pat(i, mode)));
        end
    endtask

    task automatic expect_pulses(input string tag, input int done_exp, input int err_exp);
        check({tag, "_done"}, 32'(done_cnt), 32'(done_exp));
        check({tag, "_err"}, 32'(err_cnt), 32'(err_exp));
        check({tag, "_done_alone"}, 32'(done_alone), 32'd0);
        check({tag, "_both"}, 32'(both_cnt), 32'd0);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int d2[12];
        d2 = '{3, 0, 0, 0, 2, 0, 0, 0, 3, 0, 0, 0};

        repeat (3) @(negedge clk);
        check("rst_valid", 32'(pixel_valid), 32'd0);
        check("rst_addr", 32'(pixel_addr), 32'd0);
        check("rst_data", 32'(pixel_data), 32'd0);
        check("rst_done", 32'(packet_done), 32'd0);
        check("rst_err", 32'(packet_error), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        idle(2);

        // 1: ramp packet at 0x140
        clear_mon();
        send_hdr(24'h000140);
        send_pixels(0, NPIX, 0);
        idle(4);
        expect_writes("t1", NPIX, 32'h140, 0, 0);
        expect_pulses("t1", 1, 0);

        // 2: explicit header dibits, pixel 0xB4 as dibits 0,1,3,2
        clear_mon();
        for (int i = 0; i < 12; i++) drive_dibit(2'(d2[i]));
        drive_dibit(2'd0); drive_dibit(2'd1); drive_dibit(2'd3); drive_dibit(2'd2);
        send_pixels(1, NPIX - 1, 0);
        idle(4);
        if (wq_addr.size() > 0) begin
            check("t2_addr0", 32'(wq_addr[0]), 32'h10203);
            check("t2_data0", 32'(wq_data[0]), 32'hB4);
        end else begin
            check("t2_first_write", 32'd0, 32'd1);
        end
        expect_writes("t2", NPIX, 32'h10203, 0, 1);
        expect_pulses("t2", 1, 0);

        // 3: abort after 100 bytes + 2 dibits, then a clean packet
        clear_mon();
        send_hdr(24'h000800);
        send_pixels(0, 100, 1);
        drive_dibit(2'd1);
        drive_dibit(2'd2);
        idle(4);
        expect_writes("t3a", 100, 32'h800, 1, 0);
        expect_pulses("t3a", 0, 1);
        clear_mon();
        send_hdr(24'h002000);
        send_pixels(0, NPIX, 1);
        idle(4);
        expect_writes("t3b", NPIX, 32'h2000, 1, 0);
        expect_pulses("t3b", 1, 0);

        // 4: abort inside header
        clear_mon();
        for (int i = 0; i < 5; i++) drive_dibit(2'(i));
        @(posedge clk);
        #1 check("t4_busy_hdr", 32'(busy), 32'd1);
        idle(4);
        expect_writes("t4", 0, 0, 0, 0);
        expect_pulses("t4", 0, 1);

        // 5: address wrap plus 40 trailing dibits
        clear_mon();
        send_hdr(24'h01FFFF);
        send_pixels(0, NPIX, 1);
        for (int i = 0; i < 40; i++) drive_dibit(2'(i % 4));
        idle(4);
        if (wq_addr.size() >= 2) begin
            check("t5_addr0", 32'(wq_addr[0]), 32'h1FFFF);
            check("t5_addr1", 32'(wq_addr[1]), 32'h00000);
        end
        expect_writes("t5", NPIX, 32'h1FFFF, 1, 0);
        expect_pulses("t5", 1, 0);

        // 6: async reset mid-pixel phase
        clear_mon();
        send_hdr(24'h000300);
        send_pixels(0, 50, 0);
        @(posedge clk);
        #2 check("t6_valid_pre", 32'(pixel_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_valid", 32'(pixel_valid), 32'd0);
        check("t6_addr", 32'(pixel_addr), 32'd0);
        check("t6_data", 32'(pixel_data), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(packet_done), 32'd0);
        check("t6_err", 32'(packet_error), 32'd0);
        idle(3);
        rst = 1'b0;
        expect_pulses("t6_rst", 0, 0);
        idle(2);
        clear_mon();
        send_hdr(24'h004000);
        send_pixels(0, NPIX, 0);
        idle(4);
        expect_writes("t6", NPIX, 32'h4000, 0, 0);
        expect_pulses("t6", 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
